// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared state type, constants and memory address helpers for cal_acquire
package cal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_ZERO,
    S_ACC_REF,
    S_DIV,
    S_WRITE
  } state_t;

  localparam int N_CH       = 8;
  localparam int MULT_SHIFT = 10;
  localparam int UNITY_MULT = 1 << MULT_SHIFT;

  // Calibration memory layout: {ch, 0} holds the offset, {ch, 1} the multiplier.
  function automatic logic [3:0] cal_addr(input logic [2:0] ch, input logic is_mult);
    return {ch, is_mult};
  endfunction

  function automatic logic [2:0] addr_ch(input logic [3:0] addr);
    return addr[3:1];
  endfunction

  function automatic logic addr_is_mult(input logic [3:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/cal_div.sv
// rtl/cal_div.sv - sequential unsigned restoring divider, one quotient bit per cycle
module cal_div #(
  parameter int DW = 26,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic [DW-1:0] quotient,
  output logic          valid
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic [VW-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          valid_q;
  logic [VW:0]   shifted;
  logic          take;

  always_comb begin
    shifted = {rem_q, quo_q[DW-1]};
    take    = (shifted >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        dvs_q  <= divisor;
        cnt_q  <= CW'(DW);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        // The partial remainder always stays below the divisor, so VW bits suffice.
        quo_q <= {quo_q[DW-2:0], take};
        rem_q <= take ? VW'(shifted - {1'b0, dvs_q}) : shifted[VW-1:0];
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_q;
  assign valid    = valid_q;

endmodule

// File: rtl/cal_acquire.sv
// rtl/cal_acquire.sv - offset/gain acquisition writing the 16-word calibration memory
// Optional CAL_TIMEOUT_EN: 16-bit sample_clk watchdog that aborts a stalled ACC phase.
module cal_acquire
  import cal_pkg::*;
#(
  parameter int W          = 16,
  parameter int LOG2_N_AVG = 8,
  parameter int REF_TARGET = 16000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_clk,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  input  logic [W-1:0] in5,
  input  logic [W-1:0] in6,
  input  logic [W-1:0] in7,
  input  logic         start_zero,
  input  logic         start_ref,
  output logic         busy,
  output logic         zero_valid,
  output logic         done,
  output logic         err,
  output logic [3:0]   mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         mem_we,
  input  logic         mem_ready
);

  localparam int AW = W + LOG2_N_AVG;
  localparam int DW = W + MULT_SHIFT;
  localparam logic [DW-1:0] DIVIDEND = DW'(REF_TARGET) << MULT_SHIFT;
  localparam logic [W-1:0]  SAT_MAX  = {1'b0, {(W-1){1'b1}}};

  logic signed [W-1:0]  in_w   [N_CH];
  logic signed [AW-1:0] sum_w  [N_CH];
  logic signed [W-1:0]  mean_w [N_CH];
  logic signed [AW-1:0] acc_q  [N_CH];
  logic signed [W-1:0]  off_q  [N_CH];
  logic signed [W-1:0]  avg_q  [N_CH];
  logic [W-1:0]         mult_q [N_CH];

  state_t                state_q;
  logic                  sclk_q;
  logic                  edge_w;
  logic [LOG2_N_AVG-1:0] cnt_q;
  logic [2:0]            ch_q;
  logic                  div_run_q;
  logic signed [W:0]     denom_w;
  logic                  denom_pos;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_valid;
  logic [DW-1:0]         div_quo;
  logic [W-1:0]          sat_w;
  logic [3:0]            nxt_addr_w;
  logic [W-1:0]          word_w;

  logic         busy_q, zero_valid_q, done_q, err_q, mem_we_q;
  logic [3:0]   mem_addr_q;
  logic [W-1:0] mem_wdata_q;
`ifdef CAL_TIMEOUT_EN
  logic [15:0]  wd_q;
`endif

  assign in_w[0] = in0;
  assign in_w[1] = in1;
  assign in_w[2] = in2;
  assign in_w[3] = in3;
  assign in_w[4] = in4;
  assign in_w[5] = in5;
  assign in_w[6] = in6;
  assign in_w[7] = in7;

  assign edge_w = sample_clk & ~sclk_q;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sum_w[c]  = acc_q[c] + {{LOG2_N_AVG{in_w[c][W-1]}}, in_w[c]};
      mean_w[c] = W'(sum_w[c] >>> LOG2_N_AVG);
    end
  end

  // Gain denominator is one bit wider than a sample so avg - offset never wraps.
  always_comb begin
    denom_w   = {avg_q[ch_q][W-1], avg_q[ch_q]} - {off_q[ch_q][W-1], off_q[ch_q]};
    denom_pos = !denom_w[W] && (denom_w != '0);
    div_start = (state_q == S_DIV) && !div_run_q && denom_pos && !div_busy;
    sat_w     = (div_quo[DW-1:W-1] != '0) ? SAT_MAX : div_quo[W-1:0];
  end

  always_comb begin
    nxt_addr_w = (state_q == S_WRITE) ? mem_addr_q + 4'd1 : cal_addr(3'd0, 1'b0);
    word_w     = addr_is_mult(nxt_addr_w) ? mult_q[addr_ch(nxt_addr_w)]
                                          : off_q[addr_ch(nxt_addr_w)];
  end

  cal_div #(.DW(DW), .VW(W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (denom_w[W-1:0]),
    .busy     (div_busy),
    .quotient (div_quo),
    .valid    (div_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sclk_q       <= 1'b0;
      cnt_q        <= '0;
      ch_q         <= '0;
      div_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      zero_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c]  <= '0;
        off_q[c]  <= '0;
        avg_q[c]  <= '0;
        mult_q[c] <= '0;
      end
`ifdef CAL_TIMEOUT_EN
      wd_q <= '0;
`endif
    end else begin
      sclk_q <= sample_clk;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_zero || (start_ref && zero_valid_q)) begin
            state_q <= start_zero ? S_ACC_ZERO : S_ACC_REF;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
`ifdef CAL_TIMEOUT_EN
            wd_q <= '0;
`endif
          end else if (start_ref) begin
            err_q <= 1'b1;
          end
        end

        S_ACC_ZERO, S_ACC_REF: begin
          if (edge_w) begin
            cnt_q <= cnt_q + 1'b1;
            for (int c = 0; c < N_CH; c++) acc_q[c] <= sum_w[c];
            if (&cnt_q) begin
              if (state_q == S_ACC_ZERO) begin
                for (int c = 0; c < N_CH; c++) off_q[c] <= mean_w[c];
                zero_valid_q <= 1'b1;
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
              end else begin
                for (int c = 0; c < N_CH; c++) avg_q[c] <= mean_w[c];
                ch_q      <= '0;
                div_run_q <= 1'b0;
                state_q   <= S_DIV;
              end
            end
          end
`ifdef CAL_TIMEOUT_EN
          if (edge_w) begin
            wd_q <= '0;
          end else if (wd_q == 16'hFFFF) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
`endif
        end

        S_DIV: begin
          if ((!div_run_q && !denom_pos) || (div_run_q && div_valid)) begin
            mult_q[ch_q] <= div_run_q ? sat_w : W'(UNITY_MULT);
            if (!div_run_q) err_q <= 1'b1;
            div_run_q <= 1'b0;
            if (ch_q == 3'(N_CH - 1)) begin
              state_q     <= S_WRITE;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= nxt_addr_w;
              mem_wdata_q <= word_w;
            end else begin
              ch_q <= ch_q + 3'd1;
            end
          end else if (div_start) begin
            div_run_q <= 1'b1;
          end
        end

        S_WRITE: begin
          if (mem_ready) begin
            if (mem_addr_q == 4'd15) begin
              mem_we_q <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              mem_addr_q  <= nxt_addr_w;
              mem_wdata_q <= word_w;
            end
          end
        end

        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign zero_valid = zero_valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cal_acquire.sv
// tb/tb_cal_acquire.sv - directed self-checking bench for cal_acquire with LOG2_N_AVG=2
`timescale 1ns/1ps
module tb_cal_acquire;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_clk = 1'b0;
  logic        start_zero = 1'b0;
  logic        start_ref = 1'b0;
  logic        mem_ready = 1'b1;
  logic [15:0] in_v [8];
  logic        busy, zero_valid, done, err, mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;

  cal_acquire #(.W(16), .LOG2_N_AVG(2), .REF_TARGET(16000)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .start_zero(start_zero), .start_ref(start_ref),
    .busy(busy), .zero_valid(zero_valid), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wcount = 0;
  int done_cnt = 0;
  int stall_viol = 0;
  logic [3:0]  w_addr [64];
  logic [15:0] w_data [64];
  logic        pend = 1'b0;
  logic [3:0]  p_addr = '0;
  logic [15:0] p_data = '0;
  logic [15:0] vin [4][8];
  logic [15:0] exp_w [16];

  // Write-port observer: logs accepted writes and flags any change while stalled.
  always @(posedge clk) begin
    if (pend && (!mem_we || mem_addr !== p_addr || mem_wdata !== p_data)) stall_viol++;
    pend   = rst_n && mem_we && !mem_ready;
    p_addr = mem_addr;
    p_data = mem_wdata;
    if (rst_n && mem_we && mem_ready) begin
      if (wcount < 64) begin
        w_addr[wcount] = mem_addr;
        w_data[wcount] = mem_wdata;
      end
      wcount++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rows(input logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7);
    for (int k = 0; k < 4; k++) begin
      vin[k][0] = v0; vin[k][1] = v1; vin[k][2] = v2; vin[k][3] = v3;
      vin[k][4] = v4; vin[k][5] = v5; vin[k][6] = v6; vin[k][7] = v7;
    end
  endtask

  task automatic run_phase(input logic zp, input logic rp, input int nedges);
    @(negedge clk);
    start_zero = zp;
    start_ref  = rp;
    @(negedge clk);
    start_zero = 1'b0;
    start_ref  = 1'b0;
    for (int k = 0; k < nedges; k++) begin
      for (int c = 0; c < 8; c++) in_v[c] = vin[k][c];
      sample_clk = 1'b1;
      @(negedge clk);
      sample_clk = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag, input bit stall, input int limit);
    int n = 0;
    while (busy === 1'b1 && n < limit) begin
      if (stall) mem_ready = (n % 4 == 0);
      n++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    check({tag, "_finished_in_time"}, (n < limit), 1);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_write_count"}, wcount - base, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_addr%0d", tag, i), w_addr[base + i], i);
      check($sformatf("%s_data%0d", tag, i), w_data[base + i], exp_w[i]);
    end
  endtask

  initial begin
    int base;
    int dbase;
    for (int c = 0; c < 8; c++) in_v[c] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_zero_valid", zero_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start_ref before any zero phase is rejected
    start_ref = 1'b1;
    @(negedge clk);
    start_ref = 1'b0;
    check("ref_first_err", err, 1);
    check("ref_first_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("ref_first_no_writes", wcount, 0);

    // Both starts together: zero phase wins; ch0 offset -100
    set_rows(-16'sd100, 0, 0, 0, 0, 0, 0, 0);
    run_phase(1'b1, 1'b1, 4);
    check("both_zero_valid", zero_valid, 1);
    check("both_busy", busy, 0);
    check("both_err_cleared", err, 0);
    check("both_no_writes", wcount, 0);

    // Ref phase A: unity, x2, saturation, non-integer quotients, no err
    set_rows(16'd15900, 16'd8000, 16'd16000, 16'd400, 16'd16000, 16'd3000, 16'd4000, 16'd32767);
    exp_w = '{16'hFF9C, 16'd1024, 16'd0, 16'd2048, 16'd0, 16'd1024, 16'd0, 16'd32767,
              16'd0, 16'd1024, 16'd0, 16'd5461, 16'd0, 16'd4096, 16'd0, 16'd500};
    base  = wcount;
    dbase = done_cnt;
    run_phase(1'b0, 1'b1, 4);
    wait_idle("refA", 1'b0, 2000);
    check_writes("refA", base);
    check("refA_done_once", done_cnt - dbase, 1);
    check("refA_done_low", done, 0);
    check("refA_err", err, 0);

    // Zero phase B: varying samples exercise truncating arithmetic shift
    set_rows(-16'sd100, 0, 16'd50, 0, 0, 0, 0, 0);
    vin[0][1] = 16'd10; vin[1][1] = 16'd11; vin[2][1] = 16'd12; vin[3][1] = 16'd14;
    vin[0][6] = -16'sd1; vin[1][6] = -16'sd2; vin[2][6] = -16'sd2; vin[3][6] = -16'sd2;
    run_phase(1'b1, 1'b0, 4);
    check("zeroB_busy", busy, 0);
    check("zeroB_zero_valid", zero_valid, 1);

    // Ref phase B with stalling memory: zero/negative denominators set err
    set_rows(16'd15900, 16'd8011, 16'd50, 16'd400, 16'd0, 16'd16000, 16'd3998, 16'd32767);
    exp_w = '{16'hFF9C, 16'd1024, 16'd11, 16'd2048, 16'd50, 16'd1024, 16'd0, 16'd32767,
              16'd0, 16'd1024, 16'd0, 16'd1024, 16'hFFFE, 16'd4096, 16'd0, 16'd500};
    base  = wcount;
    dbase = done_cnt;
    run_phase(1'b0, 1'b1, 4);
    wait_idle("refB", 1'b1, 3000);
    check_writes("refB", base);
    check("refB_stall_stable", stall_viol, 0);
    check("refB_done_once", done_cnt - dbase, 1);
    check("refB_err", err, 1);

    // Reset in the middle of ACC_REF
    base = wcount;
    set_rows(16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000);
    run_phase(1'b0, 1'b1, 2);
    check("midref_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_zero_valid", zero_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample_clk = 1'b1;
      @(negedge clk);
      sample_clk = 1'b0;
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check("postrst_no_writes", wcount - base, 0);
    check("postrst_busy", busy, 0);

`ifdef CAL_TIMEOUT_EN
    // Watchdog: no sample edges during ACC_ZERO
    run_phase(1'b1, 1'b0, 0);
    check("wd_busy_start", busy, 1);
    wait_idle("wd", 1'b0, 70000);
    check("wd_err", err, 1);
    check("wd_zero_valid", zero_valid, 0);
    check("wd_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
